// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: one P/Q cell reused MSB to LSB over N cycles.
// Optional SERIAL_CMP_EARLY_EXIT_EN ends the scan as soon as the result is decided.
module serial_mag_comparator #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a_in,
    input  logic [N-1:0]  b_in,
    output logic          busy,
    output logic          done,
    output logic          gt,
    output logic          eq,
    output logic          lt,
    output logic          p_out,
    output logic          q_out,
    output logic [IW-1:0] bit_idx
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_p;
    logic          r_q;
    logic [IW-1:0] r_idx;
    logic          r_gt;
    logic          r_eq;
    logic          r_lt;

    logic w_bit_a;
    logic w_bit_b;
    logic w_p_next;
    logic w_q_next;
    logic w_last;
    logic w_finish;

    // Cell rule: only the "equal so far" state (Q=1) can change; 10 and 00 are sticky.
    always_comb begin
        w_bit_a  = r_a[r_idx];
        w_bit_b  = r_b[r_idx];
        w_p_next = r_p;
        w_q_next = r_q;
        if (r_q) begin
            if (w_bit_a && !w_bit_b) begin
                w_p_next = 1'b1;
                w_q_next = 1'b0;
            end else if (!w_bit_a && w_bit_b) begin
                w_p_next = 1'b0;
                w_q_next = 1'b0;
            end
        end
        w_last = (r_idx == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        w_finish = w_last || !w_q_next;
`else
        w_finish = w_last;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
            r_q     <= 1'b1;
            r_idx   <= IDX_TOP;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_p     <= 1'b0;
                        r_q     <= 1'b1;
                        r_idx   <= IDX_TOP;
                        r_gt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_p <= w_p_next;
                    r_q <= w_q_next;
                    if (!w_last) begin
                        r_idx <= r_idx - IW'(1);
                    end
                    if (w_finish) begin
                        r_gt    <= w_p_next & ~w_q_next;
                        r_eq    <= ~w_p_next & w_q_next;
                        r_lt    <= ~w_p_next & ~w_q_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign gt      = r_gt;
    assign eq      = r_eq;
    assign lt      = r_lt;
    assign p_out   = r_p;
    assign q_out   = r_q;
    assign bit_idx = r_idx;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator (N=3); latency expectations follow
// SERIAL_CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_serial_mag_comparator;

    localparam int N = 3;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam int LAT_GT = 2;
    localparam int LAT_LT = 1;
`else
    localparam int LAT_GT = 3;
    localparam int LAT_LT = 3;
`endif
    localparam int LAT_EQ = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;
    logic         p_out;
    logic         q_out;
    logic [1:0]   bit_idx;

    int checks = 0;
    int errors = 0;

    serial_mag_comparator #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .gt      (gt),
        .eq      (eq),
        .lt      (lt),
        .p_out   (p_out),
        .q_out   (q_out),
        .bit_idx (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_cmp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int lat, input logic [2:0] exp_res);
        int n;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        chk({tag, "_acc"}, {busy, done, gt, eq, lt, p_out, q_out, bit_idx}, {7'b1000001, 2'd2});
        wait_done(n);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, {gt, eq, lt}, exp_res);
        tick();
        chk({tag, "_idle"}, {busy, done, gt, eq, lt}, {2'b00, exp_res});
    endtask

    initial begin
        int n;
        int done_seen;
        rst   = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset", {busy, done, gt, eq, lt, p_out, q_out, bit_idx}, {7'b0000001, 2'd2});
        tick();
        tick();
        rst = 1'b0;
        tick();

        // A=110, B=101: step-by-step P/Q trace
        start = 1'b1;
        a_in  = 3'b110;
        b_in  = 3'b101;
        tick();
        start = 1'b0;
        chk("gt_k", {busy, p_out, q_out, bit_idx}, {3'b101, 2'd2});
        tick();
        chk("gt_k1", {p_out, q_out, bit_idx}, {2'b01, 2'd1});
        tick();
        chk("gt_k2_pq", {p_out, q_out}, 2'b10);
        n = 2;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("gt_lat", n, LAT_GT);
        chk("gt_res", {gt, eq, lt}, 3'b100);
        tick();
        chk("gt_idle", {busy, done, gt, eq, lt}, 5'b00100);

        do_cmp("eq011", 3'b011, 3'b011, LAT_EQ, 3'b010);
        do_cmp("lt", 3'b001, 3'b100, LAT_LT, 3'b001);
        do_cmp("gt111", 3'b111, 3'b110, LAT_EQ, 3'b100);

        // Start held high with changing operands while busy
        start = 1'b1;
        a_in  = 3'b001;
        b_in  = 3'b100;
        tick();
        chk("ign_acc", {busy, gt, eq, lt}, 4'b1000);
        n = 0;
        while (!done && n < 20) begin
            a_in = a_in + 3'd3;
            b_in = b_in - 3'd1;
            tick();
            n++;
        end
        chk("ign_lat", n, LAT_LT);
        chk("ign_res", {gt, eq, lt}, 3'b001);
        a_in = 3'b111;
        b_in = 3'b000;
        tick();
        chk("ign_done_edge", {busy, done, lt}, 3'b001);
        tick();
        start = 1'b0;
        chk("ign_next_acc", {busy, gt, eq, lt, bit_idx}, {4'b1000, 2'd2});
        wait_done(n);
        chk("ign_next_res", {gt, eq, lt}, 3'b100);
        tick();

        // Reset pulsed across edge k+2 of an A=110, B=101 compare
        start = 1'b1;
        a_in  = 3'b110;
        b_in  = 3'b101;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_async", {busy, done, gt, eq, lt, p_out, q_out, bit_idx}, {7'b0000001, 2'd2});
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) done_seen = 1;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        do_cmp("eq000", 3'b000, 3'b000, LAT_EQ, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
